// File: rtl/data_delay_line.sv
// data_delay_line: multi-channel signed delay line, delay selectable 0..MAX_DEPTH.
// Latency: depth_q en-cycles from din to dout (0 = combinational pass-through).
// Backpressure: en=0 stalls every stage; there is no ready, and the upstream must hold off.
// Ports: clk/reset (async, active-high), en, flush (sync clear), depth_sel,
//        din_valid/din in; dout_valid/dout out, primed (fill reached depth),
//        cfg_err (registered depth_sel > MAX_DEPTH).
module data_delay_line #(
  parameter int WIDTH     = 18,
  parameter int CHANNELS  = 1,
  parameter int MAX_DEPTH = 8,
  localparam int DW       = $clog2(MAX_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      flush,
  input  logic [DW-1:0]             depth_sel,
  input  logic                      din_valid,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic                      dout_valid,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      primed,
  output logic                      cfg_err
);

  localparam int BW = CHANNELS * WIDTH;
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);

  logic [BW-1:0]        stg_dat [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] stg_vld;
  logic [DW-1:0]        depth_q;
  logic [DW-1:0]        fill;
  logic                 over;
  logic [DW-1:0]        eff;

  // Out-of-range requests clamp to the deepest tap and raise cfg_err.
  assign over = (depth_sel > MAX_D);
  assign eff  = over ? MAX_D : depth_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        stg_dat[i] <= '0;
      end
      stg_vld <= '0;
      depth_q <= '0;
      fill    <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= over;
      if (flush) begin
        for (int i = 0; i < MAX_DEPTH; i++) begin
          stg_dat[i] <= '0;
        end
        stg_vld <= '0;
        fill    <= '0;
      end else if (eff != depth_q) begin
        // Retargeting the tap invalidates everything in flight: samples
        // already in the pipe were timed for the old delay. Data bits are
        // left in place and no shift happens on this edge.
        depth_q <= eff;
        stg_vld <= '0;
        fill    <= '0;
      end else if (en) begin
        stg_dat[0] <= din;
        stg_vld[0] <= din_valid;
        for (int i = 1; i < MAX_DEPTH; i++) begin
          stg_dat[i] <= stg_dat[i-1];
          stg_vld[i] <= stg_vld[i-1];
        end
        // fill never exceeds depth_q (both cleared together), so saturate there.
        if (fill < depth_q) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  // Tap mux: depth 0 bypasses the stages entirely, otherwise stage depth_q-1.
  always_comb begin
    dout       = din;
    dout_valid = din_valid;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) begin
        dout       = stg_dat[i];
        dout_valid = stg_vld[i];
      end
    end
  end

  assign primed = (fill == depth_q);

endmodule

// File: tb/tb_data_delay_line.sv
module tb_data_delay_line;

  localparam int WIDTH = 18;
  localparam int CH    = 2;
  localparam int MAXD  = 8;
  localparam int DW    = $clog2(MAXD + 1);

  logic                clk = 1'b0;
  logic                reset;
  logic                en;
  logic                flush;
  logic [DW-1:0]       depth_sel;
  logic                din_valid;
  logic [CH*WIDTH-1:0] din;
  logic                dout_valid;
  logic [CH*WIDTH-1:0] dout;
  logic                primed;
  logic                cfg_err;

  int checks   = 0;
  int failures = 0;

  data_delay_line #(.WIDTH(WIDTH), .CHANNELS(CH), .MAX_DEPTH(MAXD)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .flush      (flush),
    .depth_sel  (depth_sel),
    .din_valid  (din_valid),
    .din        (din),
    .dout_valid (dout_valid),
    .dout       (dout),
    .primed     (primed),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       fl;
    logic [3:0] ds;
    logic       v;
    int         i0;
    int         i1;
    logic       ev;
    int         e0;
    int         e1;
    logic       ep;
    logic       ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en_i, logic fl_i, logic [3:0] ds_i, logic v_i,
                              int i0, int i1, logic ev, int e0, int e1,
                              logic ep, logic ec);
    vec_t r;
    r.en = en_i; r.fl = fl_i; r.ds = ds_i; r.v = v_i; r.i0 = i0; r.i1 = i1;
    r.ev = ev; r.e0 = e0; r.e1 = e1; r.ep = ep; r.ec = ec;
    return r;
  endfunction

  function automatic logic [CH*WIDTH-1:0] pk(int a, int b);
    logic [31:0] ua;
    logic [31:0] ub;
    ua = a;
    ub = b;
    return {ub[WIDTH-1:0], ua[WIDTH-1:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input int e0, input int e1,
                         input logic ep, input logic ec);
    chk({tag, " dout"},       64'(dout),       64'(pk(e0, e1)));
    chk({tag, " dout_valid"}, 64'(dout_valid), 64'(ev));
    chk({tag, " primed"},     64'(primed),     64'(ep));
    chk({tag, " cfg_err"},    64'(cfg_err),    64'(ec));
  endtask

  initial begin
    // Each row: inputs held across one rising edge, expected outputs just after it.
    // Test 1: depth 2, -5 then 7.
    vecs.push_back(mk(1,0,2,0,   0,   0, 0,   0,   0, 0,0)); // depth change edge
    vecs.push_back(mk(1,0,2,1,  -5,   0, 0,   0,   0, 0,0));
    vecs.push_back(mk(1,0,2,1,   7,   0, 1,  -5,   0, 1,0));
    vecs.push_back(mk(1,0,2,0,   0,   0, 1,   7,   0, 1,0));
    vecs.push_back(mk(1,0,2,0,   0,   0, 0,   0,   0, 1,0));
    // Test 2: depth 3, two lanes, en 1,0,1,1 then a stall holding dout.
    vecs.push_back(mk(1,0,3,0,   0,   0, 0,   7,   0, 0,0)); // change: stage2 data kept, invalid
    vecs.push_back(mk(1,0,3,1, 100,-100, 0,   0,   0, 0,0));
    vecs.push_back(mk(0,0,3,1,   1,   1, 0,   0,   0, 0,0));
    vecs.push_back(mk(1,0,3,0,   0,   0, 0,   0,   0, 0,0));
    vecs.push_back(mk(1,0,3,0,   0,   0, 1, 100,-100, 1,0));
    vecs.push_back(mk(0,0,3,1,   5,   5, 1, 100,-100, 1,0));
    vecs.push_back(mk(1,0,3,0,   0,   0, 0,   0,   0, 1,0));
    // Test 3: depth 4 running, then switch to 1.
    vecs.push_back(mk(1,0,4,1,   1,  -1, 0, 100,-100, 0,0));
    vecs.push_back(mk(1,0,4,1,  11, -11, 0,   0,   0, 0,0));
    vecs.push_back(mk(1,0,4,1,  12, -12, 0,   0,   0, 0,0));
    vecs.push_back(mk(1,0,4,1,  13, -13, 0,   0,   0, 0,0));
    vecs.push_back(mk(1,0,4,1,  14, -14, 1,  11, -11, 1,0));
    vecs.push_back(mk(1,0,1,1,  15, -15, 0,  14, -14, 0,0));
    vecs.push_back(mk(1,0,1,1,  21, -21, 1,  21, -21, 1,0));
    // Test 5: flush mid-stream at depth 4.
    vecs.push_back(mk(1,0,4,1,  31, -31, 0,  12, -12, 0,0));
    vecs.push_back(mk(1,0,4,1,  32, -32, 0,  13, -13, 0,0));
    vecs.push_back(mk(1,0,4,1,  33, -33, 0,  14, -14, 0,0));
    vecs.push_back(mk(1,1,4,1,  34, -34, 0,   0,   0, 0,0)); // flush
    vecs.push_back(mk(1,0,4,0,   0,   0, 0,   0,   0, 0,0));
    vecs.push_back(mk(1,0,4,0,   0,   0, 0,   0,   0, 0,0));
    vecs.push_back(mk(1,0,4,0,   0,   0, 0,   0,   0, 0,0));
    vecs.push_back(mk(1,0,4,1,  41, -41, 0,   0,   0, 1,0));
    vecs.push_back(mk(1,0,4,0,   0,   0, 0,   0,   0, 1,0));
    vecs.push_back(mk(1,0,4,0,   0,   0, 0,   0,   0, 1,0));
    vecs.push_back(mk(1,0,4,0,   0,   0, 1,  41, -41, 1,0));
    // Test 4: over-range depth clamps to MAX_DEPTH with cfg_err.
    vecs.push_back(mk(1,0,MAXD+3,0, 0,   0, 0,   0,   0, 0,1));
    vecs.push_back(mk(1,0,MAXD+3,1,51, -51, 0,   0,   0, 0,1));
    vecs.push_back(mk(1,0,MAXD+3,0, 0,   0, 0,   0,   0, 0,1));
    vecs.push_back(mk(1,0,MAXD+3,0, 0,   0, 0,   0,   0, 0,1));
    vecs.push_back(mk(1,0,MAXD+3,0, 0,   0, 0,  41, -41, 0,1)); // stale data, valid cleared
    vecs.push_back(mk(1,0,MAXD+3,0, 0,   0, 0,   0,   0, 0,1));
    vecs.push_back(mk(1,0,MAXD+3,0, 0,   0, 0,   0,   0, 0,1));
    vecs.push_back(mk(1,0,MAXD+3,0, 0,   0, 0,   0,   0, 0,1));
    vecs.push_back(mk(1,0,MAXD+3,0, 0,   0, 1,  51, -51, 1,1));
    // Depth 0: combinational pass-through regardless of en.
    vecs.push_back(mk(1,0,0,1,  61, -61, 1,  61, -61, 1,0));
    vecs.push_back(mk(0,0,0,0, -62,  62, 0, -62,  62, 1,0));
    vecs.push_back(mk(1,0,0,1,  63, -63, 1,  63, -63, 1,0));
    // Exactly MAX_DEPTH is legal.
    vecs.push_back(mk(1,0,MAXD,0,   0,   0, 0,   0,   0, 0,0));

    reset = 1'b1; en = 1'b0; flush = 1'b0; depth_sel = '0;
    din_valid = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 1, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      en        = vecs[i].en;
      flush     = vecs[i].fl;
      depth_sel = vecs[i].ds;
      din_valid = vecs[i].v;
      din       = pk(vecs[i].i0, vecs[i].i1);
      @(posedge clk);
      #1;
      chk_out($sformatf("row%0d", i), vecs[i].ev, vecs[i].e0, vecs[i].e1,
              vecs[i].ep, vecs[i].ec);
    end
    flush = 1'b0;

    // Async reset mid-stream at depth 4.
    en = 1'b1; depth_sel = 4'd4; din_valid = 1'b1; din = pk(71, -71);
    @(posedge clk); // depth change edge
    for (int n = 72; n <= 75; n++) begin
      #1;
      din = pk(n, -n);
      @(posedge clk);
    end
    #1;
    chk("pre_reset dout", 64'(dout), 64'(pk(72, -72)));
    chk("pre_reset dout_valid", 64'(dout_valid), 64'(1));
    #1;
    din = '0; din_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_out("async_reset", 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk_out("held_reset", 0, 0, 0, 1, 0);
    @(negedge clk);
    reset = 1'b0;
    din = pk(81, -81); din_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_out("post_reset_change", 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      din = pk(81 + k, -(81 + k));
      @(posedge clk);
      #1;
      if (k < 3) begin
        chk_out($sformatf("post_reset%0d", k), 0, 0, 0, 0, 0);
      end else begin
        chk_out("post_reset3", 1, 81, -81, 1, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
